// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants, scan control word and RGB565 helpers
// shared by the VGA scan controller and its delay line.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Control bits that travel alongside the colour pipeline
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } scan_ctl_t;

    localparam scan_ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

    // Pin colour keeps the top four bits of each RGB565 field
    function automatic logic [11:0] rgb565_to_444(input logic [15:0] c);
        return {c[15:12], c[10:7], c[4:1]};
    endfunction

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// Pixel interface between the scan controller (master) and the colour
// blocks (slave): scan coordinates out, merged RGB565 colour back.
interface vga_scan_ctrl_if;

    logic [9:0]  x;
    logic [8:0]  y;
    logic        active;
    logic [15:0] color;

    modport master (output x, y, active, input  color);
    modport slave  (input  x, y, active, output color);

endinterface

// File: rtl/vga_sync_delay.sv
// Pixel-enable gated shift register that delays the sync/active control
// bits so they reach the pins together with the colour they belong to.
module vga_sync_delay #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= {DEPTH{RST_VAL}};
        end else if (en) begin
            r_stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan master: h/v counters, sync decode, frame/line strobes and the
// registered pin stage aligned to the colour blocks' read latency.
module vga_scan_ctrl
    import vga_timing_pkg::*;
#(
    parameter int P_H_ACTIVE = H_ACTIVE,
    parameter int P_H_FP     = H_FP,
    parameter int P_H_SYNC   = H_SYNC,
    parameter int P_H_BP     = H_BP,
    parameter int P_V_ACTIVE = V_ACTIVE,
    parameter int P_V_FP     = V_FP,
    parameter int P_V_SYNC   = V_SYNC,
    parameter int P_V_BP     = V_BP,
    parameter int LAT        = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pix_en,
    vga_scan_ctrl_if.master pix,
    output logic            frame_start,
    output logic            line_end,
    output logic [3:0]      vga_r,
    output logic [3:0]      vga_g,
    output logic [3:0]      vga_b,
    output logic            vga_hs,
    output logic            vga_vs
);

    localparam int H_TOT = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP;
    localparam int V_TOT = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP;

    localparam logic [9:0] L_H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] L_H_ACT  = 10'(P_H_ACTIVE);
    localparam logic [9:0] L_H_SS   = 10'(P_H_ACTIVE + P_H_FP);
    localparam logic [9:0] L_H_SE   = 10'(P_H_ACTIVE + P_H_FP + P_H_SYNC);
    localparam logic [9:0] L_V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] L_V_ACT  = 10'(P_V_ACTIVE);
    localparam logic [9:0] L_V_SS   = 10'(P_V_ACTIVE + P_V_FP);
    localparam logic [9:0] L_V_SE   = 10'(P_V_ACTIVE + P_V_FP + P_V_SYNC);

    logic [9:0]  r_hcnt;
    logic [9:0]  r_vcnt;
    logic        w_h_last;
    logic        w_v_last;
    scan_ctl_t   w_ctl_raw;
    scan_ctl_t   w_ctl_dly;
    logic        r_hs;
    logic        r_vs;
    logic [11:0] r_rgb;

    assign w_h_last = (r_hcnt == L_H_LAST);
    assign w_v_last = (r_vcnt == L_V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (pix_en) begin
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + 10'd1;
            end else begin
                r_hcnt <= r_hcnt + 10'd1;
            end
        end
    end

    assign w_ctl_raw.hs  = !((r_hcnt >= L_H_SS) && (r_hcnt < L_H_SE));
    assign w_ctl_raw.vs  = !((r_vcnt >= L_V_SS) && (r_vcnt < L_V_SE));
    assign w_ctl_raw.act = (r_hcnt < L_H_ACT) && (r_vcnt < L_V_ACT);

    // y deliberately drops vcnt[9]; rows 512..524 are blanking anyway
    assign pix.x      = r_hcnt;
    assign pix.y      = r_vcnt[8:0];
    assign pix.active = w_ctl_raw.act;

    // Counters sit at (0,0) throughout reset, so qualify with rst_n
    assign frame_start = rst_n && pix_en && (r_hcnt == '0) && (r_vcnt == '0);
    assign line_end    = rst_n && pix_en && w_h_last;

    vga_sync_delay #(
        .WIDTH   (3),
        .DEPTH   (LAT),
        .RST_VAL (CTL_IDLE)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en),
        .d     (w_ctl_raw),
        .q     (w_ctl_dly)
    );

    // Colour is only trusted while the delayed active flag is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_rgb <= '0;
        end else if (pix_en) begin
            r_hs  <= w_ctl_dly.hs;
            r_vs  <= w_ctl_dly.vs;
            r_rgb <= w_ctl_dly.act ? rgb565_to_444(pix.color) : 12'h000;
        end
    end

    assign vga_hs = r_hs;
    assign vga_vs = r_vs;
    assign vga_r  = r_rgb[11:8];
    assign vga_g  = r_rgb[7:4];
    assign vga_b  = r_rgb[3:0];

endmodule
